// File: rtl/multiport_register_file.sv
// -----------------------------------------------------------------------------
// multiport_register_file
//
// Parametrised register file for the issue/writeback path. It provides
// num_read combinational read ports and two write ports; port B wins when both
// write the same entry. Bypass is optional. Entry 0 can be hardwired to zero.
// A per-entry busy scoreboard lets issue logic hold reads that depend on a
// pending producer.
//
// Ports
//   Clock           rising-edge clock
//   Reset           synchronous, active-high; clears all entries and busy bits
//   Read_Addr       num_read packed read addresses (port i at [i*addr_size +:])
//   Data_Out        num_read packed read data      (port i at [i*word_size +:])
//   Read_Ready      per-port valid: entry not busy, or data forwarded
//   Write_Enable_A / Write_Addr_A / Data_In_A   write port A
//   Write_Enable_B / Write_Addr_B / Data_In_B   write port B (wins collisions)
//   Reserve_Enable / Reserve_Addr               mark an entry busy
// -----------------------------------------------------------------------------
module multiport_register_file #(
  parameter int word_size = 32,
  parameter int addr_size = 5,
  parameter int depth     = 32,
  parameter int num_read  = 2,
  parameter int zero_reg  = 1,
  parameter int bypass    = 1
) (
  input  logic                          Clock,
  input  logic                          Reset,
  input  logic [num_read*addr_size-1:0] Read_Addr,
  output logic [num_read*word_size-1:0] Data_Out,
  output logic [num_read-1:0]           Read_Ready,
  input  logic                          Write_Enable_A,
  input  logic [addr_size-1:0]          Write_Addr_A,
  input  logic [word_size-1:0]          Data_In_A,
  input  logic                          Write_Enable_B,
  input  logic [addr_size-1:0]          Write_Addr_B,
  input  logic [word_size-1:0]          Data_In_B,
  input  logic                          Reserve_Enable,
  input  logic [addr_size-1:0]          Reserve_Addr
);

  // An address names real storage when it is inside the array and is not the
  // hardwired zero entry. Everything else reads as 0/ready and absorbs writes
  // and reservations.
  function automatic logic is_storage(input logic [addr_size-1:0] addr);
    logic in_range;
    in_range = 32'(addr) < 32'(depth);
    return in_range && !((zero_reg != 0) && (addr == '0));
  endfunction

  logic [word_size-1:0] mem_reg [depth];
  logic [depth-1:0]     busy_reg;

  logic wr_a_ok;
  logic wr_b_ok;
  logic res_ok;

  // Reset masks the write qualifiers, so a write presented during reset is
  // neither committed nor forwarded.
  assign wr_a_ok = Write_Enable_A && !Reset && is_storage(Write_Addr_A);
  assign wr_b_ok = Write_Enable_B && !Reset && is_storage(Write_Addr_B);
  assign res_ok  = Reserve_Enable && !Reset && is_storage(Reserve_Addr);

  // Assignments are ordered so that the later nonblocking assignment wins.
  // B overrides A on data. A reservation overrides a write's busy clear, so
  // the new producer keeps the entry busy while the write data still lands.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      for (int i = 0; i < depth; i++) begin
        mem_reg[i] <= '0;
      end
      busy_reg <= '0;
    end else begin
      if (wr_a_ok) begin
        mem_reg[Write_Addr_A]  <= Data_In_A;
        busy_reg[Write_Addr_A] <= 1'b0;
      end
      if (wr_b_ok) begin
        mem_reg[Write_Addr_B]  <= Data_In_B;
        busy_reg[Write_Addr_B] <= 1'b0;
      end
      if (res_ok) begin
        busy_reg[Reserve_Addr] <= 1'b1;
      end
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < num_read; gi++) begin : g_read
      logic [addr_size-1:0] rd_addr;
      logic [word_size-1:0] rd_data;
      logic                 rd_ready;

      assign rd_addr = Read_Addr[gi*addr_size +: addr_size];

      // A forwarded write counts as ready even if the entry is busy, since
      // it is the producer's result arriving.
      always_comb begin
        rd_data  = '0;
        rd_ready = 1'b1;
        if ((bypass != 0) && wr_b_ok && (Write_Addr_B == rd_addr)) begin
          rd_data = Data_In_B;
        end else if ((bypass != 0) && wr_a_ok && (Write_Addr_A == rd_addr)) begin
          rd_data = Data_In_A;
        end else if (is_storage(rd_addr)) begin
          rd_data  = mem_reg[rd_addr];
          rd_ready = ~busy_reg[rd_addr];
        end
      end

      assign Data_Out[gi*word_size +: word_size] = rd_data;
      assign Read_Ready[gi]                      = rd_ready;
    end
  endgenerate

endmodule

// File: tb/tb_multiport_register_file.sv
module tb_multiport_register_file;

  localparam int WS    = 32;
  localparam int AS    = 5;
  localparam int DEPTH = 24;  // below 2**AS so out-of-range addresses exist
  localparam int NR    = 3;

  logic             Clock;
  logic             Reset;
  logic [NR*AS-1:0] Read_Addr;
  logic [NR*WS-1:0] Data_Out;
  logic [NR-1:0]    Read_Ready;
  logic             Write_Enable_A, Write_Enable_B, Reserve_Enable;
  logic [AS-1:0]    Write_Addr_A, Write_Addr_B, Reserve_Addr;
  logic [WS-1:0]    Data_In_A, Data_In_B;

  multiport_register_file #(
    .word_size(WS), .addr_size(AS), .depth(DEPTH),
    .num_read(NR), .zero_reg(1), .bypass(1)
  ) dut (
    .Clock(Clock), .Reset(Reset),
    .Read_Addr(Read_Addr), .Data_Out(Data_Out), .Read_Ready(Read_Ready),
    .Write_Enable_A(Write_Enable_A), .Write_Addr_A(Write_Addr_A), .Data_In_A(Data_In_A),
    .Write_Enable_B(Write_Enable_B), .Write_Addr_B(Write_Addr_B), .Data_In_B(Data_In_B),
    .Reserve_Enable(Reserve_Enable), .Reserve_Addr(Reserve_Addr)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference state: contents and pending-producer flags of real entries.
  logic [WS-1:0] ref_mem  [DEPTH];
  bit            ref_busy [DEPTH];

  task automatic check(input string name, input logic [WS-1:0] act, input logic [WS-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic bit real_entry(input int a);
    return (a > 0) && (a < DEPTH);
  endfunction

  // What a reader of address a should see right now, given current inputs.
  function automatic void model_read(input int a, output logic [WS-1:0] d, output logic r);
    bit a_ok, b_ok;
    a_ok = !Reset && Write_Enable_A && real_entry(int'(Write_Addr_A));
    b_ok = !Reset && Write_Enable_B && real_entry(int'(Write_Addr_B));
    d = '0;
    r = 1'b1;
    if (!real_entry(a)) return;
    if (b_ok && int'(Write_Addr_B) == a) d = Data_In_B;
    else if (a_ok && int'(Write_Addr_A) == a) d = Data_In_A;
    else begin
      d = ref_mem[a];
      r = !ref_busy[a];
    end
  endfunction

  // Apply the current inputs to the reference state, as one clock edge does.
  task automatic model_edge();
    if (Reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        ref_mem[i]  = '0;
        ref_busy[i] = 0;
      end
    end else begin
      if (Write_Enable_A && real_entry(int'(Write_Addr_A))) begin
        ref_mem[Write_Addr_A]  = Data_In_A;
        ref_busy[Write_Addr_A] = 0;
      end
      if (Write_Enable_B && real_entry(int'(Write_Addr_B))) begin
        ref_mem[Write_Addr_B]  = Data_In_B;
        ref_busy[Write_Addr_B] = 0;
      end
      if (Reserve_Enable && real_entry(int'(Reserve_Addr)))
        ref_busy[Reserve_Addr] = 1;
    end
  endtask

  // Inputs are already set (at the falling edge). Check every port against
  // the model, then clock once and return at the next falling edge.
  task automatic step();
    logic [WS-1:0] d;
    logic          r;
    #1;
    for (int p = 0; p < NR; p++) begin
      model_read(int'(Read_Addr[p*AS +: AS]), d, r);
      check($sformatf("model_p%0d_data addr %0d", p, Read_Addr[p*AS +: AS]), Data_Out[p*WS +: WS], d);
      check($sformatf("model_p%0d_ready addr %0d", p, Read_Addr[p*AS +: AS]), WS'(Read_Ready[p]), WS'(r));
    end
    @(posedge Clock);
    model_edge();
    @(negedge Clock);
  endtask

  task automatic idle_inputs();
    Reset = 0; Write_Enable_A = 0; Write_Enable_B = 0; Reserve_Enable = 0;
    Write_Addr_A = '0; Write_Addr_B = '0; Reserve_Addr = '0;
    Data_In_A = '0; Data_In_B = '0;
  endtask

  typedef struct {
    logic          rst;
    logic          wea; logic [AS-1:0] wa; logic [WS-1:0] da;
    logic          web; logic [AS-1:0] wb; logic [WS-1:0] db;
    logic          re;  logic [AS-1:0] ra;
    logic [AS-1:0] rd;
    logic [WS-1:0] exp_d;
    logic          exp_r;
  } vec_t;

  vec_t vecs [21];

  initial begin
    // Rows run in order; each row is one cycle, and expectations are for port
    // 0 in that cycle, before the edge commits the row's writes.
    //         rst wea wa da            web wb db            re ra  rd exp_d         exp_r
    vecs[0]  = '{0, 0, 0, 32'h0,        0, 0, 32'h0,        0, 0,  5, 32'h0,        1};
    vecs[1]  = '{0, 1, 5, 32'hDEADBEEF, 0, 0, 32'h0,        0, 0,  5, 32'hDEADBEEF, 1};
    vecs[2]  = '{0, 0, 0, 32'h0,        0, 0, 32'h0,        0, 0,  5, 32'hDEADBEEF, 1};
    vecs[3]  = '{0, 1, 7, 32'h11111111, 1, 7, 32'h22222222, 0, 0,  7, 32'h22222222, 1};
    vecs[4]  = '{0, 0, 0, 32'h0,        0, 0, 32'h0,        0, 0,  7, 32'h22222222, 1};
    vecs[5]  = '{0, 1, 0, 32'hFFFFFFFF, 0, 0, 32'h0,        1, 0,  0, 32'h0,        1};
    vecs[6]  = '{0, 0, 0, 32'h0,        0, 0, 32'h0,        0, 0,  0, 32'h0,        1};
    vecs[7]  = '{0, 0, 0, 32'h0,        0, 0, 32'h0,        1, 9,  9, 32'h0,        1};
    vecs[8]  = '{0, 0, 0, 32'h0,        0, 0, 32'h0,        0, 0,  9, 32'h0,        0};
    vecs[9]  = '{0, 0, 0, 32'h0,        1, 9, 32'h9,        0, 0,  9, 32'h9,        1};
    vecs[10] = '{0, 0, 0, 32'h0,        0, 0, 32'h0,        0, 0,  9, 32'h9,        1};
    vecs[11] = '{0, 0, 0, 32'h0,        1, 9, 32'h99,       1, 9,  9, 32'h99,       1};
    vecs[12] = '{0, 0, 0, 32'h0,        0, 0, 32'h0,        0, 0,  9, 32'h99,       0};
    vecs[13] = '{0, 1, 3, 32'h33,       0, 0, 32'h0,        0, 0,  3, 32'h33,       1};
    vecs[14] = '{1, 1, 3, 32'h44,       0, 0, 32'h0,        1, 4,  5, 32'hDEADBEEF, 1};
    vecs[15] = '{0, 0, 0, 32'h0,        0, 0, 32'h0,        0, 0,  3, 32'h0,        1};
    vecs[16] = '{0, 0, 0, 32'h0,        0, 0, 32'h0,        0, 0,  4, 32'h0,        1};
    vecs[17] = '{0, 1, 24, 32'hAAAA,    1, 30, 32'hBBBB,    1, 24, 24, 32'h0,       1};
    vecs[18] = '{0, 0, 0, 32'h0,        0, 0, 32'h0,        1, 23, 31, 32'h0,       1};
    vecs[19] = '{0, 0, 0, 32'h0,        0, 0, 32'h0,        0, 0,  23, 32'h0,       0};
    vecs[20] = '{0, 1, 23, 32'h5,       0, 0, 32'h0,        0, 0,  23, 32'h5,       1};

    idle_inputs();
    Read_Addr = '0;
    for (int i = 0; i < DEPTH; i++) begin
      ref_mem[i]  = 'x;
      ref_busy[i] = 0;
    end

    // Initial reset
    @(negedge Clock);
    Reset = 1;
    @(posedge Clock);
    model_edge();
    @(negedge Clock);
    Reset = 0;

    // After reset every address reads 0/ready on every port
    for (int a = 0; a < 32; a++) begin
      for (int p = 0; p < NR; p++) Read_Addr[p*AS +: AS] = AS'(a);
      #1;
      for (int p = 0; p < NR; p++) begin
        check($sformatf("reset_p%0d_data addr %0d", p, a), Data_Out[p*WS +: WS], 32'h0);
        check($sformatf("reset_p%0d_ready addr %0d", p, a), WS'(Read_Ready[p]), 32'h1);
      end
    end
    @(negedge Clock);

    // Directed vectors
    for (int v = 0; v < 21; v++) begin
      Reset = vecs[v].rst;
      Write_Enable_A = vecs[v].wea; Write_Addr_A = vecs[v].wa; Data_In_A = vecs[v].da;
      Write_Enable_B = vecs[v].web; Write_Addr_B = vecs[v].wb; Data_In_B = vecs[v].db;
      Reserve_Enable = vecs[v].re;  Reserve_Addr = vecs[v].ra;
      Read_Addr[0*AS +: AS] = vecs[v].rd;
      Read_Addr[1*AS +: AS] = vecs[v].rd + AS'(1);
      Read_Addr[2*AS +: AS] = ~vecs[v].rd;
      #1;
      check($sformatf("vec%0d_data", v), Data_Out[0 +: WS], vecs[v].exp_d);
      check($sformatf("vec%0d_ready", v), WS'(Read_Ready[0]), WS'(vecs[v].exp_r));
      $display("vec %0d: rd %0d data %h ready %0d", v, vecs[v].rd, Data_Out[0 +: WS], Read_Ready[0]);
      step();
    end
    idle_inputs();

    // Hand sequence: reserve 12, both ports write 12 the next cycle
    // while port 1 reads it; the entry must become ready with B's data.
    Reserve_Enable = 1; Reserve_Addr = 12;
    for (int p = 0; p < NR; p++) Read_Addr[p*AS +: AS] = 12;
    step();
    idle_inputs();
    #1;
    check("seq_busy_after_reserve", WS'(Read_Ready[1]), 32'h0);
    Write_Enable_A = 1; Write_Addr_A = 12; Data_In_A = 32'hA0A0;
    Write_Enable_B = 1; Write_Addr_B = 12; Data_In_B = 32'hB0B0;
    #1;
    check("seq_fwd_data", Data_Out[1*WS +: WS], 32'hB0B0);
    check("seq_fwd_ready", WS'(Read_Ready[1]), 32'h1);
    step();
    idle_inputs();
    #1;
    check("seq_after_data", Data_Out[1*WS +: WS], 32'hB0B0);
    check("seq_after_ready", WS'(Read_Ready[1]), 32'h1);

    // Randomised traffic against the reference model
    for (int c = 0; c < 400; c++) begin
      Reset          = ($urandom_range(0, 59) == 0);
      Write_Enable_A = $urandom_range(0, 1);
      Write_Addr_A   = AS'($urandom_range(0, 31));
      Data_In_A      = $urandom;
      Write_Enable_B = $urandom_range(0, 1);
      Write_Addr_B   = ($urandom_range(0, 3) == 0) ? Write_Addr_A : AS'($urandom_range(0, 31));
      Data_In_B      = $urandom;
      Reserve_Enable = ($urandom_range(0, 2) == 0);
      Reserve_Addr   = AS'($urandom_range(0, 31));
      for (int p = 0; p < NR; p++)
        Read_Addr[p*AS +: AS] = ($urandom_range(0, 2) == 0) ? Write_Addr_B : AS'($urandom_range(0, 31));
      if (c % 50 == 0)
        $display("random cycle %0d: wa %0d wb %0d res %0d", c, Write_Addr_A, Write_Addr_B, Reserve_Addr);
      step();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
